// File: rtl/clock_pkg.sv
// Shared BCD time-of-day types and limits for the clock blocks.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package clock_pkg;

    // Two packed BCD digits: tens in [7:4], units in [3:0].
    typedef logic [7:0] bcd2_t;

    localparam bcd2_t BCD_00 = 8'h00;
    localparam bcd2_t BCD_59 = 8'h59;
    localparam bcd2_t BCD_23 = 8'h23;

    // True when both digits are decimal and the pair does not exceed max.
    function automatic logic bcd2_in_range(input bcd2_t v, input bcd2_t max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronises an asynchronous level and emits a one-cycle tick per rising edge.
// Latency: tick is high in the cycle after the input has crossed SYNC_STAGES flops.
// Backpressure: none; every qualified edge produces exactly one tick.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   armed_d;

    // The chain's reset zeros are not real samples of d_i. fill_q marks when
    // the last stage holds a genuine sample, so only a genuinely observed low
    // level arms the detector; an input already high at reset release
    // therefore never produces a tick.
    always_comb begin
        armed_d = armed_q;
        if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
            armed_d = 1'b1;
        end
    end

    // Synchroniser chain, fill tracker, edge history and arm flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= armed_d;
        end
    end

    assign tick_o = sync_q[SYNC_STAGES-1] & ~prev_q & armed_q;

endmodule

// File: rtl/time_counter.sv
// BCD hh:mm:ss time-of-day counter driven by a synchronised 1 Hz tick, with load port.
// Latency: tick applied SYNC_STAGES edges after clk_1Hz is first sampled high; load 1 cycle.
// Backpressure: set_ready is 0 only while in reset; an accepted load beats a same-cycle tick.
// Optional alarm compare output is built when TIME_COUNTER_ALARM_EN is defined.
module time_counter
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clk_100MHz,
    input  logic  reset,
    input  logic  clk_1Hz,
    input  logic  run_en,
    input  logic  set_valid,
    output logic  set_ready,
    input  bcd2_t set_hh,
    input  bcd2_t set_mm,
    input  bcd2_t set_ss,
    output bcd2_t hh,
    output bcd2_t mm,
    output bcd2_t ss,
    output logic  sec_pulse,
    output logic  day_pulse,
    output logic  set_err
`ifdef TIME_COUNTER_ALARM_EN
    ,
    input  bcd2_t alarm_hh,
    input  bcd2_t alarm_mm,
    output logic  alarm_hit
`endif
);

    bcd2_t hh_q, mm_q, ss_q;
    bcd2_t hh_d, mm_d, ss_d;
    bcd2_t hh_inc, mm_inc, ss_inc;
    logic  day_wrap;
    logic  sec_q, sec_d;
    logic  day_q, day_d;
    logic  err_q, err_d;
    logic  ready_q;
    logic  tick;
    logic  load_acc;
    logic  load_ok;
    logic  advance;
    logic  time_changed;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_i   (clk_100MHz),
        .reset_i (reset),
        .d_i     (clk_1Hz),
        .tick_o  (tick)
    );

    assign load_acc = set_valid & ready_q;
    assign load_ok  = bcd2_in_range(set_hh, BCD_23)
                    & bcd2_in_range(set_mm, BCD_59)
                    & bcd2_in_range(set_ss, BCD_59);
    // A valid accepted load swallows a coincident tick; a rejected one does not.
    assign advance      = tick & run_en & ~(load_acc & load_ok);
    assign time_changed = (load_acc & load_ok) | advance;

    // One-second BCD increment with digit-by-digit carry, never leaving BCD.
    always_comb begin
        ss_inc   = ss_q;
        mm_inc   = mm_q;
        hh_inc   = hh_q;
        day_wrap = 1'b0;
        if (ss_q[3:0] != 4'd9) begin
            ss_inc[3:0] = ss_q[3:0] + 4'd1;
        end else if (ss_q[7:4] != 4'd5) begin
            ss_inc = {ss_q[7:4] + 4'd1, 4'd0};
        end else begin
            ss_inc = BCD_00;
            if (mm_q[3:0] != 4'd9) begin
                mm_inc[3:0] = mm_q[3:0] + 4'd1;
            end else if (mm_q[7:4] != 4'd5) begin
                mm_inc = {mm_q[7:4] + 4'd1, 4'd0};
            end else begin
                mm_inc = BCD_00;
                if (hh_q == BCD_23) begin
                    hh_inc   = BCD_00;
                    day_wrap = 1'b1;
                end else if (hh_q[3:0] != 4'd9) begin
                    hh_inc[3:0] = hh_q[3:0] + 4'd1;
                end else begin
                    hh_inc = {hh_q[7:4] + 4'd1, 4'd0};
                end
            end
        end
    end

    // Next-state selection: load, otherwise advance, and the one-cycle pulses.
    always_comb begin
        hh_d  = hh_q;
        mm_d  = mm_q;
        ss_d  = ss_q;
        sec_d = 1'b0;
        day_d = 1'b0;
        err_d = load_acc & ~load_ok;
        if (load_acc && load_ok) begin
            hh_d = set_hh;
            mm_d = set_mm;
            ss_d = set_ss;
        end else if (advance) begin
            hh_d  = hh_inc;
            mm_d  = mm_inc;
            ss_d  = ss_inc;
            sec_d = 1'b1;
            day_d = day_wrap;
        end
    end

    // Time registers, pulse registers and load-ready flag.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            hh_q    <= BCD_00;
            mm_q    <= BCD_00;
            ss_q    <= BCD_00;
            sec_q   <= 1'b0;
            day_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            sec_q   <= sec_d;
            day_q   <= day_d;
            err_q   <= err_d;
            ready_q <= 1'b1;
        end
    end

    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign sec_pulse = sec_q;
    assign day_pulse = day_q;
    assign set_err   = err_q;
    assign set_ready = ready_q;

`ifdef TIME_COUNTER_ALARM_EN
    logic alarm_q;
    logic alarm_d;

    // Alarm fires only when time is freshly produced at hh:mm:00.
    always_comb begin
        alarm_d = time_changed && (hh_d == alarm_hh) && (mm_d == alarm_mm)
                  && (ss_d == BCD_00);
    end

    // Alarm pulse register.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm_hit = alarm_q;
`else
    logic unused_changed;
    assign unused_changed = time_changed;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: seconds-of-day reference model plus directed scenarios.
// Latency: model predicts outputs one edge after inputs are sampled.
// Backpressure: loads are offered only through the set_valid/set_ready handshake.
module tb_time_counter;

    localparam int SYNC = 2;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       clk_1Hz    = 1'b1;
    logic       run_en     = 1'b1;
    logic       set_valid  = 1'b0;
    logic       set_ready;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
    logic [7:0] hh, mm, ss;
    logic       sec_pulse, day_pulse, set_err;
`ifdef TIME_COUNTER_ALARM_EN
    logic [7:0] alarm_hh = 8'h07, alarm_mm = 8'h00;
    logic       alarm_hit;
`endif

    time_counter #(.SYNC_STAGES(SYNC)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clk_1Hz    (clk_1Hz),
        .run_en     (run_en),
        .set_valid  (set_valid),
        .set_ready  (set_ready),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_ss     (set_ss),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .sec_pulse  (sec_pulse),
        .day_pulse  (day_pulse),
        .set_err    (set_err)
`ifdef TIME_COUNTER_ALARM_EN
        ,
        .alarm_hh   (alarm_hh),
        .alarm_mm   (alarm_mm),
        .alarm_hit  (alarm_hit)
`endif
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int checks = 0;
    int errors = 0;
    int sp_seen = 0;
    int dp_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Decimal value of a BCD pair, or -1 if either digit is not decimal.
    function automatic int bcd_val(input logic [7:0] b);
        int t, u;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        if (t > 9 || u > 9) return -1;
        return t * 10 + u;
    endfunction

    function automatic logic [7:0] rand_bcd(input int max);
        if ($urandom_range(0, 3) != 0) return to_bcd($urandom_range(0, max));
        return 8'($urandom);
    endfunction

    // Reference model: time kept as seconds since midnight.
    int  cyc = 0;
    int  rst_edge = -100;
    bit  hist [0:39999];
    int  m_t = 0;
    bit  m_sp, m_dp, m_err, m_rdy, m_alarm;
    bit  model_ok = 1'b0;

    always @(posedge clk_100MHz) begin : model
        int  vh, vm, vs;
        bit  acc, ok, tick, changed;
        cyc++;
        hist[cyc] = clk_1Hz;
        if (reset) begin
            rst_edge = cyc;
            m_t = 0; m_sp = 0; m_dp = 0; m_err = 0; m_rdy = 0; m_alarm = 0;
            model_ok = 1'b1;
        end else begin
            // A rising edge between two post-reset samples is applied SYNC edges later.
            tick = (cyc > SYNC + 1) && (cyc - SYNC - 1 > rst_edge)
                   && hist[cyc - SYNC] && !hist[cyc - SYNC - 1];
            acc = set_valid && m_rdy;
            vh = bcd_val(set_hh);
            vm = bcd_val(set_mm);
            vs = bcd_val(set_ss);
            ok = (vh >= 0) && (vh < 24) && (vm >= 0) && (vm < 60) && (vs >= 0) && (vs < 60);
            m_sp = 0; m_dp = 0; m_err = acc && !ok; changed = 0;
            if (acc && ok) begin
                m_t = vh * 3600 + vm * 60 + vs;
                changed = 1;
            end else if (tick && run_en) begin
                m_t = (m_t + 1) % 86400;
                m_sp = 1;
                m_dp = (m_t == 0);
                changed = 1;
            end
            m_alarm = 0;
`ifdef TIME_COUNTER_ALARM_EN
            m_alarm = changed && (to_bcd(m_t / 3600) == alarm_hh)
                      && (to_bcd((m_t / 60) % 60) == alarm_mm) && (m_t % 60 == 0);
`endif
            m_rdy = 1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk_100MHz) begin
        if (model_ok) begin
            chk("hh", hh, to_bcd(m_t / 3600));
            chk("mm", mm, to_bcd((m_t / 60) % 60));
            chk("ss", ss, to_bcd(m_t % 60));
            chk("sec_pulse", sec_pulse, m_sp);
            chk("day_pulse", day_pulse, m_dp);
            chk("set_err", set_err, m_err);
            chk("set_ready", set_ready, m_rdy);
`ifdef TIME_COUNTER_ALARM_EN
            chk("alarm_hit", alarm_hit, m_alarm);
`endif
            if (sec_pulse === 1'b1) sp_seen++;
            if (day_pulse === 1'b1) dp_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_valid = 1'b1;
        set_hh = h; set_mm = m; set_ss = s;
        step(1);
        set_valid = 1'b0;
    endtask

    // Low long enough to arm, then high; returns at the cycle the update is visible.
    task automatic rise();
        clk_1Hz = 1'b0;
        step(SYNC + 2);
        clk_1Hz = 1'b1;
        step(SYNC + 1);
    endtask

    initial begin : stim
        int sp0, dp0, hold;
        // Reset with clk_1Hz already high: no false tick afterwards.
        step(3);
        reset = 1'b0;
        sp0 = sp_seen;
        step(10);
        chk("no_false_tick", sp_seen - sp0, 0);
        chk("ss_after_reset", ss, 8'h00);
        chk("ready_after_reset", set_ready, 1);
        clk_1Hz = 1'b0;
        step(SYNC + 2);
        clk_1Hz = 1'b1;
        step(SYNC);
        chk("ss_before_update", ss, 8'h00);
        step(1);
        chk("ss_first_tick", ss, 8'h01);
        chk("sec_pulse_first", sec_pulse, 1);

        // Midnight rollover.
        load(8'h23, 8'h59, 8'h58);
        chk("load_235958", {hh, mm, ss}, 24'h235958);
        rise();
        chk("t_235959", {hh, mm, ss}, 24'h235959);
        chk("no_day_at_59", day_pulse, 0);
        dp0 = dp_seen;
        rise();
        chk("t_000000", {hh, mm, ss}, 24'h000000);
        chk("day_pulse_wrap", day_pulse, 1);
        chk("sec_pulse_wrap", sec_pulse, 1);
        step(1);
        chk("one_day_pulse", dp_seen - dp0, 1);

        // Rejected loads.
        load(8'h24, 8'h00, 8'h00);
        chk("err_hh24", set_err, 1);
        chk("keep_on_hh24", {hh, mm, ss}, 24'h000000);
        step(1);
        chk("err_one_cycle", set_err, 0);
        load(8'h00, 8'h00, 8'h0A);
        chk("err_ss0A", set_err, 1);

        // Valid load coincident with a tick: load wins, tick dropped.
        clk_1Hz = 1'b0;
        step(SYNC + 2);
        clk_1Hz = 1'b1;
        step(SYNC);
        load(8'h12, 8'h34, 8'h56);
        chk("load_beats_tick", {hh, mm, ss}, 24'h123456);
        chk("no_sec_on_load", sec_pulse, 0);

        // Rejected load coincident with a tick: tick still applied.
        clk_1Hz = 1'b0;
        step(SYNC + 2);
        clk_1Hz = 1'b1;
        step(SYNC);
        load(8'h99, 8'h00, 8'h00);
        chk("tick_past_bad_load", {hh, mm, ss}, 24'h123457);
        chk("err_with_tick", set_err, 1);
        chk("sec_with_bad_load", sec_pulse, 1);

        // run_en low drops ticks; re-enable gives no stale tick.
        run_en = 1'b0;
        repeat (3) rise();
        run_en = 1'b1;
        step(5);
        chk("hold_when_disabled", {hh, mm, ss}, 24'h123457);
        rise();
        chk("advance_after_enable", {hh, mm, ss}, 24'h123458);

`ifdef TIME_COUNTER_ALARM_EN
        load(8'h06, 8'h59, 8'h59);
        rise();
        chk("alarm_time", {hh, mm, ss}, 24'h070000);
        chk("alarm_hit", alarm_hit, 1);
        step(1);
        chk("alarm_one_cycle", alarm_hit, 0);
`endif

        // Reset mid-operation with a load in flight.
        set_valid = 1'b1;
        set_hh = 8'h11; set_mm = 8'h11; set_ss = 8'h11;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        set_valid = 1'b0;
        chk("reset_clears_time", {hh, mm, ss}, 24'h000000);
        chk("ready_low_in_reset", set_ready, 0);
        step(1);
        chk("ready_high_after", set_ready, 1);

        // Randomised phase against the model.
        hold = 0;
        for (int i = 0; i < 6000; i++) begin
            if (hold == 0) begin
                clk_1Hz = ~clk_1Hz;
                hold = $urandom_range(0, 5);
            end else begin
                hold--;
            end
            run_en    = ($urandom_range(0, 9) != 0);
            reset     = ($urandom_range(0, 799) == 0);
            set_valid = ($urandom_range(0, 5) == 0);
            set_hh    = ($urandom_range(0, 1) == 0) ? 8'h23 : rand_bcd(23);
            set_mm    = rand_bcd(59);
            set_ss    = rand_bcd(59);
            step(1);
        end
        reset = 1'b0;
        set_valid = 1'b0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
